// File: rtl/fwd_sel_unit.sv
// Operand-forwarding controller for one issue lane.
// Tracks EX/MEM/WB writers, emits mux selects and load-use stall.
module fwd_sel_unit #(
  parameter int REG_AW = 5,
  parameter int SEL_W  = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              ID_VALID,
  input  logic [REG_AW-1:0] ID_RS1,
  input  logic [REG_AW-1:0] ID_RS2,
  input  logic [REG_AW-1:0] ID_RD,
  input  logic              ID_REGWRITE,
  input  logic              ID_IS_LOAD,
  input  logic              FLUSH,
  output logic [SEL_W-1:0]  SEL_A,
  output logic [SEL_W-1:0]  SEL_B,
  output logic              STALL,
  output logic              EX_VALID
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              is_load;
  } ent_t;

  localparam logic [SEL_W-1:0] SEL_RF  = SEL_W'(0);
  localparam logic [SEL_W-1:0] SEL_EX  = SEL_W'(1);
  localparam logic [SEL_W-1:0] SEL_MEM = SEL_W'(2);
  localparam logic [SEL_W-1:0] SEL_WB  = SEL_W'(3);

  ent_t             ex_q, ex_d;
  ent_t             mem_q, mem_d;
  ent_t             wb_q, wb_d;
  logic [SEL_W-1:0] sel_a_q, sel_a_d;
  logic [SEL_W-1:0] sel_b_q, sel_b_d;
  logic             stall;

  function automatic logic writer(input ent_t e);
    return e.valid && e.regwrite && (e.rd != '0);
  endfunction

  function automatic logic hit(
    input ent_t              e,
    input logic [REG_AW-1:0] rs
  );
    return writer(e) && (e.rd == rs);
  endfunction

  function automatic logic [SEL_W-1:0] pick(
    input logic [REG_AW-1:0] rs,
    input ent_t              ex,
    input ent_t              mem,
    input ent_t              wb
  );
    logic [SEL_W-1:0] s;
    s = SEL_RF;
    if (rs == '0)         s = SEL_RF;
    else if (hit(ex, rs)) s = SEL_EX;
    else if (hit(mem, rs)) s = SEL_MEM;
    else if (hit(wb, rs)) s = SEL_WB;
    return s;
  endfunction

  // load in EX feeding the ID instruction cannot forward yet
  always_comb begin
    stall = ID_VALID && writer(ex_q) && ex_q.is_load &&
            ((ex_q.rd == ID_RS1) || (ex_q.rd == ID_RS2)) &&
            !FLUSH;
  end

  // next tracking state and selects; flush squashes ID and EX
  always_comb begin
    ex_d    = '0;
    mem_d   = ex_q;
    wb_d    = mem_q;
    sel_a_d = SEL_RF;
    sel_b_d = SEL_RF;
    unique case (1'b1)
      FLUSH: begin
        mem_d = '0;
      end
      stall: begin
        ex_d = '0;
      end
      default: begin
        ex_d.valid    = ID_VALID;
        ex_d.rd       = ID_RD;
        ex_d.regwrite = ID_REGWRITE;
        ex_d.is_load  = ID_IS_LOAD;
        sel_a_d = pick(ID_RS1, ex_q, mem_q, wb_q);
        sel_b_d = pick(ID_RS2, ex_q, mem_q, wb_q);
      end
    endcase
  end

  // pipeline tracking registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      sel_a_q <= SEL_RF;
      sel_b_q <= SEL_RF;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      wb_q    <= wb_d;
      sel_a_q <= sel_a_d;
      sel_b_q <= sel_b_d;
    end
  end

  assign SEL_A    = sel_a_q;
  assign SEL_B    = sel_b_q;
  assign STALL    = stall;
  assign EX_VALID = ex_q.valid;

endmodule
